cache_controller: RTL and testbench

- Two-way set-associative read cache between the MEM stage and the SRAM controller.
- Read hits return in the same cycle. Read misses fetch one 64-bit block through the SRAM controller's rd_en/ready handshake and fill the cache.
- Writes are write-through and no-allocate: always forwarded to SRAM; a write hit also updates the cached word.
- `ready` low freezes the pipeline.

---
 rtl/cache_controller.sv | 159 +++++++++++++++
 tb/tb_cache_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through / no-allocate read cache sitting between
// the MEM stage and the SRAM controller. Hits answer combinationally; misses fill one 64-bit block.
module cache_controller #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_write_data,
    input  logic [63:0] sram_read_data,
    input  logic        sram_ready
);

    localparam int SETS   = 1 << INDEX_W;
    localparam int TAG_LO = INDEX_W + 3;
    localparam int TAG_HI = TAG_LO + TAG_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        READ_MISS,
        WRITE
    } state_t;

    state_t            state_q;
    logic [SETS-1:0]   valid0_q;
    logic [SETS-1:0]   valid1_q;
    logic [SETS-1:0]   lru_q;
    logic [TAG_W-1:0]  tag0_q  [SETS];
    logic [TAG_W-1:0]  tag1_q  [SETS];
    logic [63:0]       data0_q [SETS];
    logic [63:0]       data1_q [SETS];

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               wordSel;
    logic               hit0;
    logic               hit1;
    logic [63:0]        hitBlock;
    logic [31:0]        hitWord;
    logic [31:0]        fillWord;
    logic [63:0]        wrBlock;
    logic               victimWay;

    assign index    = address[INDEX_W+2:3];
    assign tag      = address[TAG_HI:TAG_LO];
    assign wordSel  = address[2];
    assign hit0     = valid0_q[index] && (tag0_q[index] == tag);
    assign hit1     = valid1_q[index] && (tag1_q[index] == tag);
    assign hitBlock = hit1 ? data1_q[index] : data0_q[index];
    assign hitWord  = wordSel ? hitBlock[63:32] : hitBlock[31:0];
    assign fillWord = wordSel ? sram_read_data[63:32] : sram_read_data[31:0];
    assign wrBlock  = wordSel ? {write_data, hitBlock[31:0]} : {hitBlock[63:32], write_data};

    // Empty ways are filled before anything is evicted; way 0 is preferred.
    assign victimWay = !valid0_q[index] ? 1'b0 :
                       !valid1_q[index] ? 1'b1 : lru_q[index];

    assign sram_write_data = write_data;

    always_comb begin
        ready        = 1'b0;
        read_data    = 32'd0;
        sram_rd_en   = 1'b0;
        sram_wr_en   = 1'b0;
        sram_address = address;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    ready = 1'b0;
                end else if (rd_en) begin
                    ready     = hit0 || hit1;
                    read_data = (hit0 || hit1) ? hitWord : 32'd0;
                end else begin
                    ready = 1'b1;
                end
            end
            READ_MISS: begin
                sram_rd_en   = 1'b1;
                sram_address = {address[31:3], 3'b000};
                ready        = sram_ready;
                read_data    = sram_ready ? fillWord : 32'd0;
            end
            WRITE: begin
                sram_wr_en = 1'b1;
                ready      = sram_ready;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en) begin
                        state_q <= WRITE;
                        if (hit0) begin
                            data0_q[index] <= wrBlock;
                            lru_q[index]   <= 1'b1;
                        end else if (hit1) begin
                            data1_q[index] <= wrBlock;
                            lru_q[index]   <= 1'b0;
                        end
                    end else if (rd_en) begin
                        if (hit0) begin
                            lru_q[index] <= 1'b1;
                        end else if (hit1) begin
                            lru_q[index] <= 1'b0;
                        end else begin
                            state_q <= READ_MISS;
                        end
                    end
                end
                READ_MISS: begin
                    // The fill happens even if the pipeline dropped rd_en meanwhile.
                    if (sram_ready) begin
                        state_q <= IDLE;
                        if (victimWay) begin
                            valid1_q[index] <= 1'b1;
                            tag1_q[index]   <= tag;
                            data1_q[index]  <= sram_read_data;
                            lru_q[index]    <= 1'b0;
                        end else begin
                            valid0_q[index] <= 1'b1;
                            tag0_q[index]   <= tag;
                            data0_q[index]  <= sram_read_data;
                            lru_q[index]    <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (sram_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Directed cycle-by-cycle vector table for the cache controller, plus hand-written
// sequences for reset during a miss and a read request withdrawn mid-miss.
module tb_cache_controller;

    typedef struct {
        logic        rst;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        sRdy;
        logic [63:0] sData;
        logic        chk;
        logic        eReady;
        logic [31:0] eData;
        logic        eSRd;
        logic        eSWr;
        logic [31:0] eSAddr;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic        sram_rd_en;
    logic        sram_wr_en;
    logic [31:0] sram_address;
    logic [31:0] sram_write_data;
    logic [63:0] sram_read_data;
    logic        sram_ready;

    int testsRun    = 0;
    int testsFailed = 0;
    vec_t tbl[$];

    cache_controller #(.INDEX_W(6), .TAG_W(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_en           (rd_en),
        .wr_en           (wr_en),
        .address         (address),
        .write_data      (write_data),
        .read_data       (read_data),
        .ready           (ready),
        .sram_rd_en      (sram_rd_en),
        .sram_wr_en      (sram_wr_en),
        .sram_address    (sram_address),
        .sram_write_data (sram_write_data),
        .sram_read_data  (sram_read_data),
        .sram_ready      (sram_ready)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic rd, input logic wr,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic sr, input logic [63:0] sd, input logic c,
                                input logic er, input logic [31:0] ed,
                                input logic esr, input logic esw, input logic [31:0] esa);
        vec_t v;
        v.rst = r;  v.rd = rd;  v.wr = wr;  v.addr = a;  v.wdata = wd;
        v.sRdy = sr; v.sData = sd; v.chk = c; v.eReady = er; v.eData = ed;
        v.eSRd = esr; v.eSWr = esw; v.eSAddr = esa;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int row,
                               input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s row %0d: got %h expected %h", name, row, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst            = v.rst;
        rd_en          = v.rd;
        wr_en          = v.wr;
        address        = v.addr;
        write_data     = v.wdata;
        sram_ready     = v.sRdy;
        sram_read_data = v.sData;
    endtask

    task automatic checkVec(input vec_t v, input int row);
        if (v.chk) begin
            checkOutput("ready", row, {31'd0, ready}, {31'd0, v.eReady});
            checkOutput("read_data", row, read_data, v.eData);
            checkOutput("sram_rd_en", row, {31'd0, sram_rd_en}, {31'd0, v.eSRd});
            checkOutput("sram_wr_en", row, {31'd0, sram_wr_en}, {31'd0, v.eSWr});
            if (v.eSRd || v.eSWr)
                checkOutput("sram_address", row, sram_address, v.eSAddr);
            if (v.eSWr)
                checkOutput("sram_write_data", row, sram_write_data, v.wdata);
        end
    endtask

    // Waits (bounded) for the SRAM read request, then completes it with blk.
    task automatic serveMiss(input logic [63:0] blk, input logic [31:0] expWord, input int row);
        int n = 0;
        @(negedge clk);
        while (!sram_rd_en && n < 8) begin
            @(negedge clk);
            n++;
        end
        checkOutput("miss_request", row, {31'd0, sram_rd_en}, 32'd1);
        sram_ready     = 1'b1;
        sram_read_data = blk;
        #2;
        checkOutput("miss_ready", row, {31'd0, ready}, 32'd1);
        checkOutput("miss_data", row, read_data, expWord);
        @(negedge clk);
        sram_ready = 1'b0;
        rd_en      = 1'b0;
    endtask

    localparam logic [63:0] B40  = 64'h22222222_11111111;
    localparam logic [63:0] B240 = 64'h44444444_33333333;
    localparam logic [63:0] B440 = 64'h66666666_55555555;
    localparam logic [63:0] B1K  = 64'h0000000A_00000005;

    initial begin
        rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
        sram_ready = 1'b0; sram_read_data = '0;

        //            rst rd wr addr      wdata         sRdy sData chk rdy data          sRd sWr sAddr
        tbl.push_back(mk(0, 0, 0, 32'h0,    32'h0,        0, 64'h0, 0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 32'h0,    32'h0,        0, 64'h0, 0, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,    32'h0,        0, 64'h0, 1, 1, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h40,   32'h0,        0, 64'h0, 1, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h40,   32'h0,        0, 64'h0, 1, 0, 32'h0,        1, 0, 32'h40));
        tbl.push_back(mk(1, 1, 0, 32'h40,   32'h0,        1, B40,   1, 1, 32'h11111111, 1, 0, 32'h40));
        tbl.push_back(mk(1, 1, 0, 32'h44,   32'h0,        0, 64'h0, 1, 1, 32'h22222222, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 32'h44,   32'hDEADBEEF, 0, 64'h0, 1, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 32'h44,   32'hDEADBEEF, 0, 64'h0, 1, 0, 32'h0,        0, 1, 32'h44));
        tbl.push_back(mk(1, 0, 1, 32'h44,   32'hDEADBEEF, 1, 64'h0, 1, 1, 32'h0,        0, 1, 32'h44));
        tbl.push_back(mk(1, 1, 0, 32'h44,   32'h0,        0, 64'h0, 1, 1, 32'hDEADBEEF, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h40,   32'h0,        0, 64'h0, 1, 1, 32'h11111111, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h240,  32'h0,        0, 64'h0, 1, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h240,  32'h0,        0, 64'h0, 1, 0, 32'h0,        1, 0, 32'h240));
        tbl.push_back(mk(1, 1, 0, 32'h240,  32'h0,        1, B240,  1, 1, 32'h33333333, 1, 0, 32'h240));
        tbl.push_back(mk(1, 1, 0, 32'h40,   32'h0,        0, 64'h0, 1, 1, 32'h11111111, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h440,  32'h0,        0, 64'h0, 1, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h440,  32'h0,        0, 64'h0, 1, 0, 32'h0,        1, 0, 32'h440));
        tbl.push_back(mk(1, 1, 0, 32'h440,  32'h0,        1, B440,  1, 1, 32'h55555555, 1, 0, 32'h440));
        tbl.push_back(mk(1, 1, 0, 32'h44,   32'h0,        0, 64'h0, 1, 1, 32'hDEADBEEF, 0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h240,  32'h0,        0, 64'h0, 1, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h240,  32'h0,        0, 64'h0, 1, 0, 32'h0,        1, 0, 32'h240));
        tbl.push_back(mk(1, 1, 0, 32'h240,  32'h0,        1, B240,  1, 1, 32'h33333333, 1, 0, 32'h240));
        tbl.push_back(mk(1, 1, 0, 32'h444,  32'h0,        0, 64'h0, 1, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h444,  32'h0,        0, 64'h0, 1, 0, 32'h0,        1, 0, 32'h440));
        tbl.push_back(mk(1, 1, 0, 32'h444,  32'h0,        1, B440,  1, 1, 32'h66666666, 1, 0, 32'h440));
        tbl.push_back(mk(1, 1, 0, 32'h444,  32'h0,        0, 64'h0, 1, 1, 32'h66666666, 0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 32'h1000, 32'h5,        0, 64'h0, 1, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 1, 32'h1000, 32'h5,        0, 64'h0, 1, 0, 32'h0,        0, 1, 32'h1000));
        tbl.push_back(mk(1, 0, 1, 32'h1000, 32'h5,        1, 64'h0, 1, 1, 32'h0,        0, 1, 32'h1000));
        tbl.push_back(mk(1, 1, 0, 32'h1000, 32'h0,        0, 64'h0, 1, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 0, 32'h1000, 32'h0,        0, 64'h0, 1, 0, 32'h0,        1, 0, 32'h1000));
        tbl.push_back(mk(1, 1, 0, 32'h1000, 32'h0,        1, B1K,   1, 1, 32'h5,        1, 0, 32'h1000));
        tbl.push_back(mk(1, 0, 0, 32'h0,    32'h0,        0, 64'h0, 1, 1, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 1, 32'h1000, 32'h7,        0, 64'h0, 1, 0, 32'h0,        0, 0, 32'h0));
        tbl.push_back(mk(1, 1, 1, 32'h1000, 32'h7,        0, 64'h0, 1, 0, 32'h0,        0, 1, 32'h1000));
        tbl.push_back(mk(1, 1, 1, 32'h1000, 32'h7,        1, 64'h0, 1, 1, 32'h0,        0, 1, 32'h1000));
        tbl.push_back(mk(1, 1, 0, 32'h1000, 32'h0,        0, 64'h0, 1, 1, 32'h7,        0, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 32'h0,    32'h0,        0, 64'h0, 1, 1, 32'h0,        0, 0, 32'h0));

        foreach (tbl[i]) begin
            @(negedge clk);
            applyStimulus(tbl[i]);
            #2;
            checkVec(tbl[i], i);
        end

        // Reset while a miss is outstanding: no fill may survive it.
        @(negedge clk);
        rd_en = 1'b1; address = 32'h800; sram_ready = 1'b0;
        #2 checkOutput("rm_miss", 100, {31'd0, ready}, 32'd0);
        @(negedge clk);
        #2 checkOutput("rm_req", 101, {31'd0, sram_rd_en}, 32'd1);
        @(negedge clk);
        rst = 1'b0; sram_ready = 1'b1; sram_read_data = 64'hBADBAD00_BADBAD01;
        @(negedge clk);
        rst = 1'b1; rd_en = 1'b0; sram_ready = 1'b0;
        #2;
        checkOutput("rm_rd_en_low", 102, {31'd0, sram_rd_en}, 32'd0);
        checkOutput("rm_idle_ready", 102, {31'd0, ready}, 32'd1);
        @(negedge clk);
        rd_en = 1'b1; address = 32'h800;
        #2 checkOutput("rm_rereadmiss", 103, {31'd0, ready}, 32'd0);
        serveMiss(64'h0000BBBB_0000AAAA, 32'h0000AAAA, 104);

        // Read request withdrawn mid-miss: access completes and the block is filled.
        @(negedge clk);
        rd_en = 1'b1; address = 32'h80;
        #2 checkOutput("drop_miss", 110, {31'd0, ready}, 32'd0);
        @(negedge clk);
        rd_en = 1'b0;
        #2 checkOutput("drop_req_held", 111, {31'd0, sram_rd_en}, 32'd1);
        @(negedge clk);
        sram_ready = 1'b1; sram_read_data = 64'h87654321_12345678;
        #2 checkOutput("drop_req_held2", 112, {31'd0, sram_rd_en}, 32'd1);
        @(negedge clk);
        sram_ready = 1'b0;
        #2 checkOutput("drop_idle", 113, {31'd0, sram_rd_en}, 32'd0);
        @(negedge clk);
        rd_en = 1'b1; address = 32'h84;
        #2;
        checkOutput("drop_hit_ready", 114, {31'd0, ready}, 32'd1);
        checkOutput("drop_hit_data", 114, read_data, 32'h87654321);
        checkOutput("drop_hit_nosram", 114, {31'd0, sram_rd_en}, 32'd0);
        @(negedge clk);
        rd_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
